// File: rtl/cdm_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : cdm_pkg
//  Description : Shared widths, default approximation depth and column-range
//                helper for the carry-disregard multiplier.
//  Revision    : 1.0  initial release
// ============================================================================
package cdm_pkg;

    localparam int OP_W                = 8;
    localparam int RES_W               = 16;
    localparam int APPROX_COLS_DEFAULT = 4;

    // Bit mask covering product columns 0..cols-1 (the carry-free field).
    function automatic logic [RES_W-1:0] low_col_mask(input int cols);
        logic [RES_W-1:0] mask;
        mask = '0;
        for (int k = 0; k < RES_W; k++) begin
            if (k < cols) mask[k] = 1'b1;
        end
        return mask;
    endfunction

endpackage
`default_nettype wire

// File: rtl/cdm8_44_mul_if.sv
`default_nettype none
// ============================================================================
//  Module      : cdm8_44_mul_if
//  Description : Operand/result bundle for the approximate multiplier.
//  Revision    : 1.0  initial release
// ============================================================================
interface cdm8_44_mul_if;
    import cdm_pkg::*;

    logic             in_valid;
    logic [OP_W-1:0]  A;
    logic [OP_W-1:0]  B;
    logic             out_valid;
    logic [RES_W-1:0] R;

    modport master (output in_valid, output A, output B, input out_valid, input R);
    modport slave  (input in_valid, input A, input B, output out_valid, output R);

endinterface
`default_nettype wire

// File: rtl/cdm_pp_core.sv
`default_nettype none
// ============================================================================
//  Module      : cdm_pp_core
//  Description : Combinational CDM core: OR-reduced low columns, exact sum of
//                the remaining partial products.
//  Revision    : 1.0  initial release
// ============================================================================
module cdm_pp_core
    import cdm_pkg::*;
#(
    parameter int APPROX_COLS = APPROX_COLS_DEFAULT
) (
    input  wire logic [OP_W-1:0]  a,
    input  wire logic [OP_W-1:0]  b,
    output logic      [RES_W-1:0] prod
);

    localparam logic [RES_W-1:0] c_low = low_col_mask(APPROX_COLS);

    logic [RES_W-1:0] w_row [OP_W];
    logic [RES_W-1:0] w_sum;
    logic [RES_W-1:0] w_or;

    // Row i holds pp[.][i] already shifted to its column weight.
    genvar gi;
    generate
        for (gi = 0; gi < OP_W; gi++) begin : g_row
            assign w_row[gi] = b[gi] ? ({{(RES_W-OP_W){1'b0}}, a} << gi) : '0;
        end
    endgenerate

    // OR of rows gives the per-column OR; masking rows before the add keeps
    // any carry from ever being generated in the low field.
    always_comb begin
        w_sum = '0;
        w_or  = '0;
        for (int i = 0; i < OP_W; i++) begin
            w_sum = w_sum + (w_row[i] & ~c_low);
            w_or  = w_or | w_row[i];
        end
        prod = w_sum | (w_or & c_low);
    end

endmodule
`default_nettype wire

// File: rtl/cdm8_44_mul.sv
`default_nettype none
// ============================================================================
//  Module      : cdm8_44_mul
//  Description : 8x8 carry-disregard approximate multiplier, 1-cycle latency,
//                registered result and valid.
//  Revision    : 1.0  initial release
// ============================================================================
module cdm8_44_mul
    import cdm_pkg::*;
#(
    parameter int APPROX_COLS = APPROX_COLS_DEFAULT
) (
    input  wire logic     clk,
    input  wire logic     rst_n,
    cdm8_44_mul_if.slave  bus
);

    logic [RES_W-1:0] w_prod;
    logic [RES_W-1:0] r_res;
    logic             r_valid;

    cdm_pp_core #(
        .APPROX_COLS (APPROX_COLS)
    ) u_core (
        .a    (bus.A),
        .b    (bus.B),
        .prod (w_prod)
    );

    // Result only loads on qualified cycles, so idle operands never reach R.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_res   <= '0;
            r_valid <= 1'b0;
        end else begin
            r_valid <= bus.in_valid;
            if (bus.in_valid) r_res <= w_prod;
        end
    end

    assign bus.R         = r_res;
    assign bus.out_valid = r_valid;

endmodule
`default_nettype wire

// File: tb/tb_cdm8_44_mul.sv
`default_nettype none
// ============================================================================
//  Module      : tb_cdm8_44_mul
//  Description : Directed and exhaustive self-checking bench for cdm8_44_mul.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_cdm8_44_mul;

    localparam int APPROX_COLS = 4;

    logic clk;
    logic rst_n;
    int   n_tests;
    int   n_fail;

    cdm8_44_mul_if bus();

    cdm8_44_mul #(.APPROX_COLS(APPROX_COLS)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Independent bit-level model: column OR below APPROX_COLS, exact sum above.
    function automatic logic [15:0] ref_mul(input logic [7:0] a, input logic [7:0] b);
        int          s;
        logic [15:0] lo;
        s  = 0;
        lo = '0;
        for (int i = 0; i < 8; i++)
            for (int j = 0; j < 8; j++)
                if (a[i] && b[j]) begin
                    if (i + j < APPROX_COLS) lo[i+j] = 1'b1;
                    else                     s = s + (1 << (i + j));
                end
        return s[15:0] | lo;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [7:0] a, input logic [7:0] b);
        bus.in_valid = v;
        bus.A        = a;
        bus.B        = b;
    endtask

    logic [7:0]  va [6];
    logic [7:0]  vb [6];
    logic [15:0] vr [6];

    initial begin
        int p;
        n_tests = 0;
        n_fail  = 0;
        va = '{8'd0,   8'd1,   8'd16,  8'd3, 8'd15, 8'd255};
        vb = '{8'd255, 8'd255, 8'd16,  8'd3, 8'd15, 8'd255};
        vr = '{16'd0,  16'd255, 16'd256, 16'd7, 16'd191, 16'hFDDF};

        // Reset state
        rst_n = 1'b0;
        drive(1'b0, 8'd0, 8'd0);
        #1;
        chk("reset_R", {16'd0, bus.R}, 32'd0);
        chk("reset_valid", {31'd0, bus.out_valid}, 32'd0);
        step();
        step();
        @(negedge clk);
        rst_n = 1'b1;
        step();
        chk("idle_valid", {31'd0, bus.out_valid}, 32'd0);

        // Directed vectors, one at a time with idle gaps
        for (int k = 0; k < 6; k++) begin
            drive(1'b1, va[k], vb[k]);
            step();
            chk($sformatf("vec%0d_R", k), {16'd0, bus.R}, {16'd0, vr[k]});
            chk($sformatf("vec%0d_valid", k), {31'd0, bus.out_valid}, 32'd1);
            drive(1'b0, 8'd0, 8'd0);
            step();
        end

        // Back-to-back throughput
        drive(1'b1, 8'd3, 8'd3);
        step();
        chk("b2b0_R", {16'd0, bus.R}, 32'd7);
        chk("b2b0_valid", {31'd0, bus.out_valid}, 32'd1);
        drive(1'b1, 8'd15, 8'd15);
        step();
        chk("b2b1_R", {16'd0, bus.R}, 32'd191);
        chk("b2b1_valid", {31'd0, bus.out_valid}, 32'd1);
        drive(1'b1, 8'd255, 8'd255);
        step();
        chk("b2b2_R", {16'd0, bus.R}, 32'd64991);
        chk("b2b2_valid", {31'd0, bus.out_valid}, 32'd1);

        // Drop valid: R holds even though operands change
        drive(1'b0, 8'd5, 8'd7);
        step();
        chk("hold_valid", {31'd0, bus.out_valid}, 32'd0);
        chk("hold_R", {16'd0, bus.R}, 32'd64991);
        drive(1'b0, 8'd1, 8'd1);
        step();
        chk("hold2_R", {16'd0, bus.R}, 32'd64991);

        // Asynchronous reset mid-stream, no clock edge in between
        drive(1'b1, 8'd15, 8'd15);
        step();
        chk("pre_rst_R", {16'd0, bus.R}, 32'd191);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_R", {16'd0, bus.R}, 32'd0);
        chk("async_rst_valid", {31'd0, bus.out_valid}, 32'd0);
        step();
        chk("rst_hold_R", {16'd0, bus.R}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        drive(1'b1, 8'd16, 8'd16);
        step();
        chk("post_rst_R", {16'd0, bus.R}, 32'd256);
        chk("post_rst_valid", {31'd0, bus.out_valid}, 32'd1);

        // Exhaustive sweep against the model plus error-bound checks
        for (int a = 0; a < 256; a++) begin
            for (int b = 0; b < 256; b++) begin
                drive(1'b1, a[7:0], b[7:0]);
                step();
                p = a * b;
                chk($sformatf("sweep_%0d_%0d", a, b), {16'd0, bus.R}, {16'd0, ref_mul(a[7:0], b[7:0])});
                chk($sformatf("bound_le_%0d_%0d", a, b), {31'd0, (int'(bus.R) <= p)}, 32'd1);
                chk($sformatf("bound_err_%0d_%0d", a, b), {31'd0, ((p - int'(bus.R)) <= 49)}, 32'd1);
            end
        end
        drive(1'b0, 8'd0, 8'd0);
        step();
        chk("end_valid", {31'd0, bus.out_valid}, 32'd0);
        chk("end_R", {16'd0, bus.R}, 32'd64991);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
